// File: rtl/reconfig_pkg.sv
// Shared types for the multi-image reconfiguration controller:
// FSM state encoding and the err_code values reported to the user.
package reconfig_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      WAIT,
      FAIL
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_INVALID = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_FAIL    = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous device error flag into clk.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/multi_image_reconfig_ctrl.sv
// Drives the device reconfiguration pins for a requested image, retrying on
// error and falling back to the golden image before giving up.
module multi_image_reconfig_ctrl
   import reconfig_pkg::*;
#(
   parameter int CBSEL_W      = 2,
   parameter int NUM_IMAGES   = 4,
   parameter int GOLDEN_IMAGE = 0,
   parameter int SETUP_CYC    = 16,
   parameter int PULSE_CYC    = 8,
   parameter int WAIT_CYC     = 1024,
   parameter int MAX_RETRY    = 1,
   parameter int HB_DIV       = 2**24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   input  logic [CBSEL_W-1:0] req_image,
   output logic               req_ready,
   input  logic               cfg_ERROR,
   output logic               cfg_ENA,
   output logic [CBSEL_W-1:0] cfg_CBSEL,
   output logic               cfg_CONFIG,
   output logic               cfg_ERROR_port,
   output logic               busy,
   output logic [1:0]         err_code,
   output logic [3:0]         led
);

   localparam int LIM_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int LIM_MAX = (LIM_SP > WAIT_CYC) ? LIM_SP : WAIT_CYC;
   localparam int CNT_W   = $clog2(LIM_MAX + 1);
   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int HB_W    = $clog2(HB_DIV + 1);

   localparam logic [CNT_W-1:0]   SETUP_END  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0]   PULSE_END  = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0]   WAIT_END   = CNT_W'(WAIT_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);
   localparam logic [HB_W-1:0]    HB_END     = HB_W'(HB_DIV - 1);
   localparam logic [CBSEL_W-1:0] GOLDEN     = CBSEL_W'(GOLDEN_IMAGE);
   localparam logic [CBSEL_W:0]   NUM_IMG    = (CBSEL_W + 1)'(NUM_IMAGES);

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [RETRY_W-1:0]   retry_cnt, retry_nx;
   logic [CBSEL_W-1:0]   image, image_nx;
   logic                 fallback, fallback_nx;
   logic [1:0]           err_nx;
   logic                 err_sync;
   logic                 fail_led;
   logic [HB_W-1:0]      hb_cnt;
   logic                 hb;

   sync_2ff u_err_sync (
      .clk (clk),
      .rst (rst),
      .d   (cfg_ERROR),
      .q   (err_sync)
   );

   assign cfg_ERROR_port = err_sync;
   assign led            = {hb, fail_led, fallback, busy};

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      retry_nx    = retry_cnt;
      image_nx    = image;
      fallback_nx = fallback;
      err_nx      = err_code;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (req_valid && req_ready) begin
               if ({1'b0, req_image} >= NUM_IMG) begin
                  err_nx = ERR_INVALID;
               end else begin
                  image_nx    = req_image;
                  retry_nx    = '0;
                  fallback_nx = 1'b0;
                  err_nx      = ERR_NONE;
                  state_nx    = SETUP;
               end
            end
         end
         SETUP: begin
            if (cnt == SETUP_END) begin
               cnt_nx   = '0;
               state_nx = PULSE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         PULSE: begin
            if (cnt == PULSE_END) begin
               cnt_nx   = '0;
               state_nx = WAIT;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         WAIT: begin
            // An error seen on the last window cycle still takes priority over timeout
            if (err_sync) begin
               cnt_nx = '0;
               if (retry_cnt < RETRY_LIM) begin
                  retry_nx = retry_cnt + 1'b1;
                  state_nx = SETUP;
               end else if (image != GOLDEN) begin
                  image_nx    = GOLDEN;
                  retry_nx    = '0;
                  fallback_nx = 1'b1;
                  state_nx    = SETUP;
               end else begin
                  err_nx   = ERR_FAIL;
                  state_nx = FAIL;
               end
            end else if (cnt == WAIT_END) begin
               cnt_nx   = '0;
               err_nx   = ERR_TIMEOUT;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         FAIL: begin
            err_nx = ERR_FAIL;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         retry_cnt  <= '0;
         image      <= GOLDEN;
         fallback   <= 1'b0;
         err_code   <= ERR_NONE;
         cfg_ENA    <= 1'b0;
         cfg_CONFIG <= 1'b0;
         cfg_CBSEL  <= GOLDEN;
         busy       <= 1'b0;
         req_ready  <= 1'b0;
         fail_led   <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         retry_cnt  <= retry_nx;
         image      <= image_nx;
         fallback   <= fallback_nx;
         err_code   <= err_nx;
         cfg_ENA    <= (state_nx inside {SETUP, PULSE, WAIT});
         cfg_CONFIG <= (state_nx == PULSE);
         busy       <= (state_nx inside {SETUP, PULSE, WAIT});
         req_ready  <= (state_nx == IDLE);
         fail_led   <= (state_nx == FAIL);
         // Image select only moves when a new attempt begins
         if (state_nx == SETUP && state != SETUP)
            cfg_CBSEL <= image_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hb_cnt <= '0;
         hb     <= 1'b0;
      end else if (hb_cnt == HB_END) begin
         hb_cnt <= '0;
         hb     <= ~hb;
      end else begin
         hb_cnt <= hb_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_multi_image_reconfig_ctrl.sv
// Directed bench for multi_image_reconfig_ctrl with short timing parameters.
module tb_multi_image_reconfig_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [2:0] req_image;
   logic       req_ready;
   logic       cfg_ERROR;
   logic       cfg_ENA;
   logic [2:0] cfg_CBSEL;
   logic       cfg_CONFIG;
   logic       cfg_ERROR_port;
   logic       busy;
   logic [1:0] err_code;
   logic [3:0] led;

   int errors = 0;
   int checks = 0;
   int seen_pulses;
   bit seq_done;
   logic [2:0] seen_cb [4];

   multi_image_reconfig_ctrl #(
      .CBSEL_W(3), .NUM_IMAGES(4), .GOLDEN_IMAGE(0), .SETUP_CYC(4),
      .PULSE_CYC(2), .WAIT_CYC(16), .MAX_RETRY(1), .HB_DIV(8)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_image(req_image),
      .req_ready(req_ready), .cfg_ERROR(cfg_ERROR), .cfg_ENA(cfg_ENA),
      .cfg_CBSEL(cfg_CBSEL), .cfg_CONFIG(cfg_CONFIG),
      .cfg_ERROR_port(cfg_ERROR_port), .busy(busy), .err_code(err_code), .led(led)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [2:0] img);
      req_valid = 1'b1;
      req_image = img;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic run_seq(input int budget, input bit drop_on_fallback);
      logic prev;
      prev        = cfg_CONFIG;
      seen_pulses = 0;
      seq_done    = 1'b0;
      for (int i = 0; i < budget && !seq_done; i++) begin
         tick();
         if (cfg_CONFIG && !prev) begin
            if (seen_pulses < 4) seen_cb[seen_pulses] = cfg_CBSEL;
            seen_pulses++;
         end
         prev = cfg_CONFIG;
         if (drop_on_fallback && led[1]) cfg_ERROR = 1'b0;
         if (req_ready || led[2]) seq_done = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_image = '0; cfg_ERROR = 1'b0;
      repeat (3) tick();
      checks++;
      if ({cfg_ENA, cfg_CONFIG, busy, req_ready, cfg_ERROR_port} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {cfg_ENA, cfg_CONFIG, busy, req_ready, cfg_ERROR_port});
      end
      checks++;
      if ({cfg_CBSEL, err_code, led} !== 9'b0) begin
         errors++;
         $display("FAIL reset_data: cbsel=%0d err=%0d led=%b expected 0/0/0000",
                  cfg_CBSEL, err_code, led);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
      end
      repeat (6) tick();
      checks++;
      if (led[3] !== 1'b0) begin
         errors++; $display("FAIL heartbeat_before: got %b expected 0", led[3]);
      end
      tick();
      checks++;
      if (led[3] !== 1'b1) begin
         errors++; $display("FAIL heartbeat_toggle: got %b expected 1", led[3]);
      end
   endtask

   task automatic test_invalid();
      request(3'd5);
      checks++;
      if ({err_code, req_ready, cfg_ENA, busy} !== {2'd1, 3'b100}) begin
         errors++;
         $display("FAIL invalid_5: err=%0d ready=%b ena=%b busy=%b expected 1/1/0/0",
                  err_code, req_ready, cfg_ENA, busy);
      end
      request(3'd4);
      repeat (2) tick();
      checks++;
      if ({err_code, req_ready, cfg_ENA, cfg_CONFIG} !== {2'd1, 3'b100}) begin
         errors++;
         $display("FAIL invalid_4_sticky: err=%0d ready=%b ena=%b cfg=%b expected 1/1/0/0",
                  err_code, req_ready, cfg_ENA, cfg_CONFIG);
      end
   endtask

   task automatic test_normal();
      int cfg_early;
      cfg_early = 0;
      request(3'd2);
      checks++;
      if ({cfg_ENA, busy, req_ready, cfg_CBSEL, err_code} !== {3'b110, 3'd2, 2'd0}) begin
         errors++;
         $display("FAIL normal_accept: ena=%b busy=%b ready=%b cbsel=%0d err=%0d expected 1/1/0/2/0",
                  cfg_ENA, busy, req_ready, cfg_CBSEL, err_code);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (cfg_CONFIG !== 1'b0) cfg_early++;
      end
      checks++;
      if (cfg_early != 0) begin
         errors++; $display("FAIL normal_setup_cfg: got %0d high cycles expected 0", cfg_early);
      end
      tick();
      tick();
      checks++;
      if (cfg_CONFIG !== 1'b1) begin
         errors++; $display("FAIL normal_pulse_end: got %b expected 1", cfg_CONFIG);
      end
      tick();
      checks++;
      if ({cfg_CONFIG, cfg_ENA, busy} !== 3'b011) begin
         errors++;
         $display("FAIL normal_wait_entry: cfg/ena/busy=%b expected 011", {cfg_CONFIG, cfg_ENA, busy});
      end
      repeat (15) tick();
      checks++;
      if ({busy, err_code} !== {1'b1, 2'd0}) begin
         errors++;
         $display("FAIL normal_wait_last: busy=%b err=%0d expected 1/0", busy, err_code);
      end
      tick();
      checks++;
      if ({err_code, busy, req_ready, cfg_ENA, led[0]} !== {2'd2, 4'b0100}) begin
         errors++;
         $display("FAIL normal_timeout: err=%0d busy=%b ready=%b ena=%b led0=%b expected 2/0/1/0/0",
                  err_code, busy, req_ready, cfg_ENA, led[0]);
      end
   endtask

   task automatic test_fallback();
      cfg_ERROR = 1'b1;
      request(3'd3);
      run_seq(300, 1'b1);
      checks++;
      if (!seq_done || seen_pulses != 3) begin
         errors++;
         $display("FAIL fallback_pulses: done=%b pulses=%0d expected 1/3", seq_done, seen_pulses);
      end
      checks++;
      if ({seen_cb[0], seen_cb[1], seen_cb[2]} !== {3'd3, 3'd3, 3'd0}) begin
         errors++;
         $display("FAIL fallback_images: got %0d,%0d,%0d expected 3,3,0",
                  seen_cb[0], seen_cb[1], seen_cb[2]);
      end
      checks++;
      if ({err_code, led[2:0], req_ready} !== {2'd2, 3'b010, 1'b1}) begin
         errors++;
         $display("FAIL fallback_final: err=%0d led=%b ready=%b expected 2/010/1",
                  err_code, led[2:0], req_ready);
      end
   endtask

   task automatic test_fail();
      cfg_ERROR = 1'b1;
      request(3'd0);
      run_seq(300, 1'b0);
      checks++;
      if (!seq_done || seen_pulses != 2) begin
         errors++;
         $display("FAIL golden_pulses: done=%b pulses=%0d expected 1/2", seq_done, seen_pulses);
      end
      checks++;
      if ({led[2], err_code, req_ready, cfg_ENA, busy} !== {1'b1, 2'd3, 3'b000}) begin
         errors++;
         $display("FAIL golden_fail_state: led2=%b err=%0d ready=%b ena=%b busy=%b expected 1/3/0/0/0",
                  led[2], err_code, req_ready, cfg_ENA, busy);
      end
      cfg_ERROR = 1'b0;
      request(3'd1);
      repeat (3) tick();
      checks++;
      if ({req_ready, cfg_ENA, err_code, led[2]} !== {2'b00, 2'd3, 1'b1}) begin
         errors++;
         $display("FAIL fail_terminal: ready=%b ena=%b err=%0d led2=%b expected 0/0/3/1",
                  req_ready, cfg_ENA, err_code, led[2]);
      end
   endtask

   task automatic test_rst_mid_pulse();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({req_ready, err_code, led[2:0]} !== {1'b1, 2'd0, 3'b000}) begin
         errors++;
         $display("FAIL recover_idle: ready=%b err=%0d led=%b expected 1/0/000",
                  req_ready, err_code, led[2:0]);
      end
      request(3'd1);
      repeat (4) tick();
      checks++;
      if (cfg_CONFIG !== 1'b1) begin
         errors++; $display("FAIL midrst_in_pulse: got %b expected 1", cfg_CONFIG);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({cfg_CONFIG, cfg_ENA, busy, req_ready, cfg_CBSEL} !== 7'b0) begin
         errors++;
         $display("FAIL midrst_outputs: cfg/ena/busy/ready=%b cbsel=%0d expected 0000/0",
                  {cfg_CONFIG, cfg_ENA, busy, req_ready}, cfg_CBSEL);
      end
      rst = 1'b0;
      tick();
      request(3'd1);
      checks++;
      if ({cfg_ENA, cfg_CBSEL} !== {1'b1, 3'd1}) begin
         errors++;
         $display("FAIL midrst_reaccept: ena=%b cbsel=%0d expected 1/1", cfg_ENA, cfg_CBSEL);
      end
      run_seq(300, 1'b0);
      checks++;
      if (!seq_done || err_code !== 2'd2) begin
         errors++;
         $display("FAIL midrst_complete: done=%b err=%0d expected 1/2", seq_done, err_code);
      end
   endtask

   task automatic test_setup_error();
      request(3'd2);
      tick();
      cfg_ERROR = 1'b1;
      tick();
      checks++;
      if (cfg_ERROR_port !== 1'b0) begin
         errors++; $display("FAIL sync_latency1: got %b expected 0", cfg_ERROR_port);
      end
      cfg_ERROR = 1'b0;
      tick();
      checks++;
      if (cfg_ERROR_port !== 1'b1) begin
         errors++; $display("FAIL sync_latency2: got %b expected 1", cfg_ERROR_port);
      end
      tick();
      checks++;
      if ({cfg_ERROR_port, cfg_CONFIG} !== 2'b01) begin
         errors++;
         $display("FAIL sync_clear: port/cfg=%b expected 01", {cfg_ERROR_port, cfg_CONFIG});
      end
      run_seq(300, 1'b0);
      checks++;
      if (!seq_done || seen_pulses != 0 || err_code !== 2'd2 || led[1] !== 1'b0) begin
         errors++;
         $display("FAIL setup_err_ignored: done=%b extra_pulses=%0d err=%0d led1=%b expected 1/0/2/0",
                  seq_done, seen_pulses, err_code, led[1]);
      end
   endtask

   initial begin
      test_reset();
      test_invalid();
      test_normal();
      test_fallback();
      test_fail();
      test_rst_mid_pulse();
      test_setup_error();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
